mem_access_unit: RTL and testbench

// - Single-port memory access sequencer directly downstream of the RV32I multicycle datapath.
// - Consumes the aligned address, byte offset, store data and funct3 produced by the datapath.
// - Drives the memory handshake and generates byte enables.
// - Checks alignment, bounds the wait on mem_resp with a watchdog, and returns the raw read word plus a done pulse to control.

---
 rtl/mem_access_pkg.sv | 55 +++++
 rtl/mem_be_gen.sv | 26 ++
 rtl/mem_access_unit.sv | 116 +++++++++++
 tb/tb_mem_access_unit.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared types, funct3 width codes and the byte-enable helper
// used by the memory access sequencer and its byte-enable generator.
package mem_access_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } mau_state_t;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W
    } mau_size_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Unsigned widths exist only for loads; any other code is word width.
    function automatic mau_size_t size_for(
        input logic [2:0] funct3,
        input logic       is_write
    );
        mau_size_t sz;
        sz = SZ_W;
        if (funct3 == F3_B || (!is_write && funct3 == F3_BU))
            sz = SZ_B;
        else if (funct3 == F3_H || (!is_write && funct3 == F3_HU))
            sz = SZ_H;
        return sz;
    endfunction

    // Reads always fetch the whole word; stores touch only their lanes.
    function automatic logic [3:0] be_for(
        input logic [2:0] funct3,
        input logic [1:0] offset,
        input logic       is_write
    );
        logic [3:0] be;
        be = 4'b1111;
        if (is_write) begin
            unique case (size_for(funct3, is_write))
                SZ_B:    be = 4'b0001 << offset;
                SZ_H:    be = 4'b0011 << offset;
                default: be = 4'b1111;
            endcase
        end
        return be;
    endfunction

endpackage

// File: rtl/mem_be_gen.sv
// mem_be_gen: combinational byte-enable and alignment check.
// Ports: funct3/offset/is_write in; byte_enable, misaligned out.
module mem_be_gen
    import mem_access_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic [1:0] offset,
    input  logic       is_write,
    output logic [3:0] byte_enable,
    output logic       misaligned
);

    mau_size_t size;

    always_comb begin
        size        = size_for(funct3, is_write);
        byte_enable = be_for(funct3, offset, is_write);
        misaligned  = 1'b0;
        unique case (size)
            SZ_B:    misaligned = 1'b0;
            SZ_H:    misaligned = offset[0];
            default: misaligned = |offset;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: single-port memory access sequencer with watchdog.
// Ports: req_* from datapath, mem_* handshake, rdata_out/busy/done/errors to control.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_address,
    input  logic [1:0]  req_offset,
    input  logic [31:0] req_wdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [3:0]  mem_byte_enable,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    input  logic        mem_resp,
    input  logic [31:0] mem_rdata,
    output logic [31:0] rdata_out,
    output logic        busy,
    output logic        done,
    output logic        misaligned_err,
    output logic        timeout_err,
    output logic        req_err
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WD_W-1:0] WD_MAX  = '1;

    mau_state_t      state;
    logic [WD_W-1:0] wd_cnt;
    logic [3:0]      be_next;
    logic            mis_next;

    mem_be_gen u_be_gen (
        .funct3      (req_funct3),
        .offset      (req_offset),
        .is_write    (req_write),
        .byte_enable (be_next),
        .misaligned  (mis_next)
    );

    assign busy = (state == ACCESS);

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            wd_cnt          <= '0;
            mem_read        <= 1'b0;
            mem_write       <= 1'b0;
            mem_byte_enable <= '0;
            mem_address     <= '0;
            mem_wdata       <= '0;
            rdata_out       <= '0;
            done            <= 1'b0;
            misaligned_err  <= 1'b0;
            timeout_err     <= 1'b0;
            req_err         <= 1'b0;
        end else begin
            done           <= 1'b0;
            misaligned_err <= 1'b0;
            timeout_err    <= 1'b0;
            req_err        <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_read && req_write) begin
                        state   <= RESP;
                        done    <= 1'b1;
                        req_err <= 1'b1;
                    end else if (req_read || req_write) begin
                        if (mis_next) begin
                            state          <= RESP;
                            done           <= 1'b1;
                            misaligned_err <= 1'b1;
                        end else begin
                            state           <= ACCESS;
                            wd_cnt          <= '0;
                            mem_read        <= req_read;
                            mem_write       <= req_write;
                            mem_byte_enable <= be_next;
                            mem_address     <= req_address & ~32'h3;
                            mem_wdata       <= req_wdata;
                        end
                    end
                end
                ACCESS: begin
                    // A response in the final watchdog cycle still wins.
                    if (mem_resp) begin
                        if (mem_read)
                            rdata_out <= mem_rdata;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        state     <= RESP;
                        done      <= 1'b1;
                    end else if (wd_cnt == WD_LAST) begin
                        mem_read    <= 1'b0;
                        mem_write   <= 1'b0;
                        state       <= RESP;
                        done        <= 1'b1;
                        timeout_err <= 1'b1;
                    end else if (wd_cnt != WD_MAX) begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized and directed self-checking bench
// for mem_access_unit against a behavioural access model.
module tb_mem_access_unit;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_read = 1'b0;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_address = '0;
    logic [1:0]  req_offset = '0;
    logic [31:0] req_wdata = '0;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic        mem_resp = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] rdata_out;
    logic        busy;
    logic        done;
    logic        misaligned_err;
    logic        timeout_err;
    logic        req_err;

    int passed = 0;
    int total  = 0;
    logic [31:0] exp_rdata = '0;

    mem_access_unit #(.TIMEOUT_CYCLES(T)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_read        (req_read),
        .req_write       (req_write),
        .req_funct3      (req_funct3),
        .req_address     (req_address),
        .req_offset      (req_offset),
        .req_wdata       (req_wdata),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byte_enable (mem_byte_enable),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_resp        (mem_resp),
        .mem_rdata       (mem_rdata),
        .rdata_out       (rdata_out),
        .busy            (busy),
        .done            (done),
        .misaligned_err  (misaligned_err),
        .timeout_err     (timeout_err),
        .req_err         (req_err)
    );

    always #5 clk = ~clk;

    // Expected outcome of one request, from the access rules:
    // k is the strobe cycle in which memory answers (1 = zero wait).
    task automatic model(
        input  logic       rd,
        input  logic       wr,
        input  logic [2:0] f3,
        input  logic [1:0] off,
        input  int         k,
        output int         e_done,
        output int         e_rs,
        output int         e_ws,
        output logic [2:0] e_flags,
        output logic [3:0] e_be
    );
        int n;
        int strobes;
        if (wr)
            n = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        else
            n = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        e_be    = wr ? 4'(((1 << n) - 1) << off) : 4'hF;
        e_flags = 3'b000;
        strobes = 0;
        if (rd && wr) begin
            e_flags = 3'b100;
            e_done  = 1;
        end else if ((n == 2 && off[0]) || (n == 4 && off != 2'd0)) begin
            e_flags = 3'b010;
            e_done  = 1;
        end else if (k <= T) begin
            e_done  = k + 1;
            strobes = k;
        end else begin
            e_flags = 3'b001;
            e_done  = T + 1;
            strobes = T;
        end
        e_rs = (rd && !wr) ? strobes : 0;
        e_ws = (wr && !rd) ? strobes : 0;
    endtask

    // Drives one request and records what the DUT did, cycle by cycle
    // after the accept edge; memory answers in strobe cycle k.
    task automatic do_access(
        input  logic        rd,
        input  logic        wr,
        input  logic [2:0]  f3,
        input  logic [31:0] addr,
        input  logic [1:0]  off,
        input  logic [31:0] wd,
        input  int          k,
        input  logic [31:0] rdv,
        output int          d_cyc,
        output int          rs,
        output int          ws,
        output logic [2:0]  flags,
        output logic [3:0]  be,
        output logic        stable,
        output logic        busy_d,
        output logic [31:0] rout
    );
        @(negedge clk);
        req_read    = rd;
        req_write   = wr;
        req_funct3  = f3;
        req_address = addr;
        req_offset  = off;
        req_wdata   = wd;
        @(posedge clk);
        #1;
        req_read  = 1'b0;
        req_write = 1'b0;
        d_cyc  = -1;
        rs     = 0;
        ws     = 0;
        flags  = 3'b000;
        be     = 4'h0;
        stable = 1'b1;
        busy_d = 1'b1;
        rout   = 32'h0;
        for (int c = 1; c <= 20; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
            end
            mem_resp = 1'b0;
            if (done) begin
                d_cyc  = c;
                flags  = {req_err, misaligned_err, timeout_err};
                busy_d = busy;
                rout   = rdata_out;
                break;
            end
            if (mem_read || mem_write) begin
                if (mem_read)
                    rs++;
                if (mem_write)
                    ws++;
                if (rs + ws == 1)
                    be = mem_byte_enable;
                if (mem_address !== (addr & ~32'h3) ||
                    mem_byte_enable !== be ||
                    (wr && mem_wdata !== wd))
                    stable = 1'b0;
                if (rs + ws == k) begin
                    mem_resp  = 1'b1;
                    mem_rdata = rdv;
                end
            end
        end
        @(posedge clk);
        #1;
        mem_resp = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({mem_read, mem_write, mem_byte_enable, mem_address,
             mem_wdata, rdata_out, busy, done, misaligned_err,
             timeout_err, req_err} !== '0)
            $display("FAIL reset_outputs got nonzero rd=%b wr=%b be=%h done=%b busy=%b want all 0",
                     mem_read, mem_write, mem_byte_enable, done, busy);
        else
            passed++;
        @(negedge clk);
        rst = 1'b0;
        exp_rdata = '0;
    endtask

    task automatic test_sw_wait();
        int d, rs, ws;
        logic [2:0] fl;
        logic [3:0] be;
        logic st, bz;
        logic [31:0] ro;
        do_access(1'b0, 1'b1, 3'd2, 32'h100, 2'd0, 32'hDEADBEEF, 3,
                  32'h0, d, rs, ws, fl, be, st, bz, ro);
        total++;
        if (ws !== 3 || rs !== 0)
            $display("FAIL sw_strobe got wr=%0d rd=%0d want wr=3 rd=0", ws, rs);
        else
            passed++;
        total++;
        if (be !== 4'hF || st !== 1'b1)
            $display("FAIL sw_bus got be=%h stable=%b want be=f stable=1", be, st);
        else
            passed++;
        total++;
        if (d !== 4 || fl !== 3'b000)
            $display("FAIL sw_done got cyc=%0d flags=%b want cyc=4 flags=000", d, fl);
        else
            passed++;
    endtask

    task automatic test_lb_zero_wait();
        int d, rs, ws;
        logic [2:0] fl;
        logic [3:0] be;
        logic st, bz;
        logic [31:0] ro;
        do_access(1'b1, 1'b0, 3'd0, 32'h203, 2'd3, 32'h0, 1,
                  32'hA1B2C3D4, d, rs, ws, fl, be, st, bz, ro);
        exp_rdata = 32'hA1B2C3D4;
        total++;
        if (rs !== 1 || ws !== 0 || be !== 4'hF || st !== 1'b1)
            $display("FAIL lb_strobe got rd=%0d wr=%0d be=%h stable=%b want rd=1 wr=0 be=f stable=1",
                     rs, ws, be, st);
        else
            passed++;
        total++;
        if (d !== 2 || fl !== 3'b000)
            $display("FAIL lb_done got cyc=%0d flags=%b want cyc=2 flags=000", d, fl);
        else
            passed++;
        total++;
        if (ro !== 32'hA1B2C3D4)
            $display("FAIL lb_rdata got %h want a1b2c3d4", ro);
        else
            passed++;
    endtask

    task automatic test_sh();
        int d, rs, ws;
        logic [2:0] fl;
        logic [3:0] be;
        logic st, bz;
        logic [31:0] ro;
        do_access(1'b0, 1'b1, 3'd1, 32'h300, 2'd2, 32'h55AA0000, 2,
                  32'h0, d, rs, ws, fl, be, st, bz, ro);
        total++;
        if (be !== 4'b1100 || ws !== 2 || d !== 3)
            $display("FAIL sh_off2 got be=%b wr=%0d cyc=%0d want be=1100 wr=2 cyc=3", be, ws, d);
        else
            passed++;
        do_access(1'b0, 1'b1, 3'd1, 32'h300, 2'd1, 32'h0055AA00, 2,
                  32'h0, d, rs, ws, fl, be, st, bz, ro);
        total++;
        if (fl !== 3'b010 || d !== 1 || ws !== 0)
            $display("FAIL sh_misaligned got flags=%b cyc=%0d wr=%0d want flags=010 cyc=1 wr=0",
                     fl, d, ws);
        else
            passed++;
    endtask

    task automatic test_timeout();
        int d, rs, ws;
        logic [2:0] fl;
        logic [3:0] be;
        logic st, bz;
        logic [31:0] ro;
        do_access(1'b0, 1'b1, 3'd2, 32'h400, 2'd0, 32'h12345678, 99,
                  32'h0, d, rs, ws, fl, be, st, bz, ro);
        total++;
        if (ws !== T || d !== T + 1 || fl !== 3'b001)
            $display("FAIL timeout got wr=%0d cyc=%0d flags=%b want wr=%0d cyc=%0d flags=001",
                     ws, d, fl, T, T + 1);
        else
            passed++;
        total++;
        if (bz !== 1'b0 || busy !== 1'b0)
            $display("FAIL timeout_busy got %b/%b want 0/0", bz, busy);
        else
            passed++;
        do_access(1'b1, 1'b0, 3'd2, 32'h404, 2'd0, 32'h0, T,
                  32'hCAFEF00D, d, rs, ws, fl, be, st, bz, ro);
        exp_rdata = 32'hCAFEF00D;
        total++;
        if (rs !== T || d !== T + 1 || fl !== 3'b000 || ro !== exp_rdata)
            $display("FAIL last_cycle_resp got rd=%0d cyc=%0d flags=%b data=%h want rd=%0d cyc=%0d flags=000 data=%h",
                     rs, d, fl, ro, T, T + 1, exp_rdata);
        else
            passed++;
    endtask

    task automatic test_req_err();
        int d, rs, ws;
        logic [2:0] fl;
        logic [3:0] be;
        logic st, bz;
        logic [31:0] ro;
        do_access(1'b1, 1'b1, 3'd1, 32'h500, 2'd1, 32'h0, 1,
                  32'h0, d, rs, ws, fl, be, st, bz, ro);
        total++;
        if (fl !== 3'b100 || d !== 1 || rs + ws !== 0)
            $display("FAIL req_err got flags=%b cyc=%0d strobes=%0d want flags=100 cyc=1 strobes=0",
                     fl, d, rs + ws);
        else
            passed++;
        total++;
        if (ro !== exp_rdata)
            $display("FAIL rdata_hold got %h want %h", ro, exp_rdata);
        else
            passed++;
    endtask

    task automatic test_reset_mid_access();
        int seen_done;
        @(negedge clk);
        req_write   = 1'b1;
        req_funct3  = 3'd2;
        req_address = 32'h600;
        req_offset  = 2'd0;
        req_wdata   = 32'h0BADF00D;
        @(posedge clk);
        #1;
        req_write = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (mem_write !== 1'b1 || busy !== 1'b1)
            $display("FAIL mid_strobe got wr=%b busy=%b want 1/1", mem_write, busy);
        else
            passed++;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_rdata = '0;
        total++;
        if ({mem_read, mem_write, mem_byte_enable, mem_address,
             mem_wdata, rdata_out, busy, done, misaligned_err,
             timeout_err, req_err} !== '0)
            $display("FAIL mid_reset got wr=%b be=%h addr=%h busy=%b done=%b want all 0",
                     mem_write, mem_byte_enable, mem_address, busy, done);
        else
            passed++;
        seen_done = 0;
        repeat (T + 2) begin
            @(posedge clk);
            #1;
            if (done || mem_write)
                seen_done++;
        end
        total++;
        if (seen_done !== 0)
            $display("FAIL mid_no_done got %0d activity cycles want 0", seen_done);
        else
            passed++;
    endtask

    task automatic test_random();
        int d, rs, ws, k;
        int e_d, e_rs, e_ws;
        logic [2:0] fl, e_fl, f3;
        logic [3:0] be, e_be;
        logic st, bz, rd, wr;
        logic [31:0] ro, addr, wd, rdv;
        logic [1:0] off;
        int sel;
        int bad;
        for (int i = 0; i < 40; i++) begin
            sel  = int'($urandom_range(0, 8));
            rd   = (sel == 0) || (sel >= 5);
            wr   = (sel <= 4);
            f3   = 3'($urandom_range(0, 7));
            off  = 2'($urandom_range(0, 3));
            addr = $urandom;
            wd   = $urandom;
            rdv  = $urandom;
            k    = int'($urandom_range(1, T + 2));
            model(rd, wr, f3, off, k, e_d, e_rs, e_ws, e_fl, e_be);
            do_access(rd, wr, f3, addr, off, wd, k, rdv,
                      d, rs, ws, fl, be, st, bz, ro);
            if (rd && !wr && e_fl == 3'b000)
                exp_rdata = rdv;
            bad = 0;
            if (e_rs + e_ws == 0)
                be = e_be;
            total++;
            if (d !== e_d || fl !== e_fl || rs !== e_rs || ws !== e_ws)
                bad = 1;
            if (be !== e_be || st !== 1'b1 || bz !== 1'b0 || ro !== exp_rdata)
                bad = 1;
            if (bad != 0)
                $display("FAIL rand_%0d rd=%b wr=%b f3=%0d off=%0d k=%0d got cyc=%0d fl=%b rs=%0d ws=%0d be=%b st=%b data=%h want cyc=%0d fl=%b rs=%0d ws=%0d be=%b data=%h",
                         i, rd, wr, f3, off, k, d, fl, rs, ws, be, st, ro,
                         e_d, e_fl, e_rs, e_ws, e_be, exp_rdata);
            else
                passed++;
        end
    endtask

    initial begin
        test_reset();
        test_sw_wait();
        test_lb_zero_wait();
        test_sh();
        test_timeout();
        test_req_err();
        test_reset_mid_access();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
